imem_loader: RTL and testbench

- Write-side companion to the RV32I instruction memory: receives a program as a byte stream over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit words and drives the instruction memory write port.
- Holds the core in reset until the load completes.
- Sits between the host byte link (UART RX or testbench) and the instruction memory write port; the core's instruction fetch path is untouched.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Purpose: shared types and helpers for the instruction-memory byte-stream loader.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte address of 32-bit word idx, relative to base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Purpose: packs a byte stream into little-endian 32-bit words (first byte -> [7:0]).
// Latency: word_out/word_full are combinational with the 4th byte, so the caller can register the word on that edge.
// Backpressure: none; a byte is taken on every cycle where shift is high.
// Ports: clk, rst_n (async, active low), clr (sync clear), shift (take byte_in),
//        byte_in[7:0], word_out[31:0] (assembled word), word_full (4th byte shifting in).
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0]  cnt;
  logic [31:0] sr;

  // Right shift: new bytes enter at the top, so after four shifts the first
  // byte has walked down to [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sr  <= {byte_in, sr[31:8]};
    end
  end

  // While shifting, present the word as it will look once byte_in lands.
  assign word_out  = shift ? {byte_in, sr[31:8]} : sr;
  assign word_full = shift && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Purpose: loads a program byte stream (2-byte LE word count, then LE words) into instruction memory.
// Latency: write pulse one cycle after a word's 4th byte; done one cycle after the final write.
// Backpressure: in_ready depends on state only; high through header and data, low once the load ends.
// Ports: clk, rst_n (async, active low), start (restart from DONE/ERR), in_valid/in_data/in_ready
//        (byte stream), mem_we/mem_addr/mem_wdata (imem write port), cpu_rst_n, done, err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] widx;
  logic [15:0] hdr_n;
  logic        accept;
  logic        restart;
  logic        pk_full;
  logic [31:0] pk_word;

  assign in_ready = (state == ST_HDR_LO) || (state == ST_HDR_HI) || (state == ST_DATA);
  assign accept   = in_valid && in_ready;
  assign restart  = start && ((state == ST_DONE) || (state == ST_ERR));
  // Full count as seen on the edge that takes the high header byte.
  assign hdr_n    = {in_data, n_lo};

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart),
    .shift     (accept && (state == ST_DATA)),
    .byte_in   (in_data),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HDR_LO;
      n_lo      <= '0;
      n_words   <= '0;
      widx      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_HDR_LO: begin
          if (accept) begin
            n_lo  <= in_data;
            state <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            n_words <= hdr_n;
            if (hdr_n == 16'd0) begin
              state <= ST_DONE;
            end else if ({16'd0, hdr_n} > 32'(DEPTH_WORDS)) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pk_full) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_addr(BASE_ADDR, widx);
            mem_wdata <= pk_word;
            widx      <= widx + 16'd1;
            if (widx == n_words - 16'd1) state <= ST_FLUSH;
          end
        end
        // mem_we for the last word is high during this cycle.
        ST_FLUSH: begin
          state     <= ST_DONE;
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
        end
        // Also covers an empty program, which arrives here straight from the header.
        ST_DONE: begin
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
          if (start) begin
            state     <= ST_HDR_LO;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
            widx      <= '0;
            mem_addr  <= BASE_ADDR;
          end
        end
        ST_ERR: begin
          err <= 1'b1;
          if (start) begin
            state    <= ST_HDR_LO;
            err      <= 1'b0;
            widx     <= '0;
            mem_addr <= BASE_ADDR;
          end
        end
        default: state <= ST_HDR_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: randomized self-checking bench for imem_loader against a stream-level reference model.
// Latency: model expects each write one cycle after its word's 4th accepted byte.
// Backpressure: source holds bytes while in_ready is low; in_valid gaps are fixed, alternating or random.
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_rst_n, done, err;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nbad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  int          m_cnt;
  logic [15:0] m_n;
  logic [31:0] m_word;
  int          nwrites;
  logic [31:0] last_addr, last_data;

  // Loader takes bytes until the header is in and then exactly 4*N data bytes,
  // none at all when N is zero or too large.
  function automatic bit m_ready();
    if (m_cnt < 2) return 1'b1;
    if (m_n == 16'd0 || int'(m_n) > DEPTH) return 1'b0;
    return (m_cnt - 2) < 4 * int'(m_n);
  endfunction

  task automatic model_clear();
    m_cnt   = 0;
    m_n     = '0;
    m_word  = '0;
    nwrites = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int j;
    if (m_cnt == 0) m_n[7:0] = b;
    else if (m_cnt == 1) m_n[15:8] = b;
    else begin
      j = m_cnt - 2;
      m_word[8 * (j % 4) +: 8] = b;
      if (j % 4 == 3) exp_q.push_back('{BASE + 32'(4 * (j / 4)), m_word, cyc + 1});
    end
    m_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      if (mem_we) begin
        nwrites++;
        last_addr = mem_addr;
        last_data = mem_wdata;
        if (exp_q.size() == 0) check("spurious_we", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("we_addr", mem_addr, e.addr);
          check("we_data", mem_wdata, e.data);
          check("we_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (in_valid && in_ready) model_byte(in_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps.
  task automatic send(input logic [7:0] q[$], input int mode, output int last);
    int i = 0;
    int phase = 0;
    int budget = 0;
    last = cyc;
    while (i < q.size()) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (phase % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = q[i];
      phase++;
      @(negedge clk);
      if (in_valid && in_ready) begin
        i++;
        last = cyc;
      end
      budget++;
      if (budget > 3 * q.size() + 50) begin
        check("send_timeout", 32'(i), 32'(q.size()));
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_clear();
  endtask

  task automatic finish_load(input int last, input int n);
    at_cycle(last + 1);
    check("done_early", {31'd0, done}, 32'd0);
    at_cycle(last + 2);
    check("done", {31'd0, done}, 32'd1);
    check("cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("err_clear", {31'd0, err}, 32'd0);
    check("write_count", 32'(nwrites), 32'(n));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic void add_word(inout logic [7:0] q[$], input logic [31:0] w);
    for (int k = 0; k < 4; k++) q.push_back(w[8 * k +: 8]);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] prog2[$];
    int last;
    int n;

    model_clear();
    #12;
    check_reset_vals();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Two-word program, continuous stream.
    prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send(prog2, 0, last);
    finish_load(last, 2);
    check("t1_last_addr", last_addr, BASE + 32'h4);
    check("t1_last_data", last_data, 32'h0010_0593);

    // Same program, valid on alternate cycles.
    pulse_start();
    check("start_clears_done", {31'd0, done}, 32'd0);
    send(prog2, 1, last);
    finish_load(last, 2);

    // Empty program.
    pulse_start();
    q = '{8'h00, 8'h00};
    send(q, 0, last);
    finish_load(last, 0);

    // Oversized header, then recovery.
    pulse_start();
    q = '{8'h01, 8'h04};
    send(q, 0, last);
    at_cycle(last + 2);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("err_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = 8'h55;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    pulse_start();
    at_cycle(cyc);
    check("start_clears_err", {31'd0, err}, 32'd0);
    q = '{8'h01, 8'h00};
    add_word(q, $urandom);
    send(q, 2, last);
    finish_load(last, 1);
    check("recover_addr", last_addr, BASE);

    // Async reset in the middle of the second word.
    pulse_start();
    q = prog2[0:7];
    send(q, 0, last);
    at_cycle(last + 2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    model_clear();
    @(negedge clk);
    #2 rst_n = 1'b1;
    q = '{8'h01, 8'h00};
    add_word(q, $urandom);
    send(q, 2, last);
    finish_load(last, 1);
    check("post_reset_addr", last_addr, BASE);

    // Random short programs with random gaps.
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      n = $urandom_range(1, 6);
      q = '{8'(n), 8'h00};
      for (int w = 0; w < n; w++) add_word(q, $urandom);
      send(q, 2, last);
      finish_load(last, n);
    end

    // Full-depth program, word i = i.
    pulse_start();
    q = '{8'(DEPTH), 8'(DEPTH >> 8)};
    for (int w = 0; w < DEPTH; w++) add_word(q, 32'(w));
    send(q, 0, last);
    finish_load(last, DEPTH);
    check("full_last_addr", last_addr, BASE + 32'(4 * (DEPTH - 1)));
    check("full_last_data", last_data, 32'(DEPTH - 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
